// File: rtl/chess_pkg.sv
// Shared chess encodings: piece codes, colour bit, square width and the
// move-generation scheduler state type.
package chess_pkg;

    localparam int SQ_W       = 6;
    localparam int COLOUR_BIT = 3;

    localparam logic [3:0] PIECE_NONE    = 4'h0;
    localparam logic [3:0] PIECE_PAWN    = 4'h1;
    localparam logic [3:0] PIECE_KNIGHT  = 4'h2;
    localparam logic [3:0] PIECE_BISHOP  = 4'h3;
    localparam logic [3:0] PIECE_ROOK    = 4'h4;
    localparam logic [3:0] PIECE_QUEEN   = 4'h5;
    localparam logic [3:0] PIECE_KING    = 4'h6;
    localparam logic [3:0] BPIECE_PAWN   = 4'h9;
    localparam logic [3:0] BPIECE_KNIGHT = 4'hA;
    localparam logic [3:0] BPIECE_BISHOP = 4'hB;
    localparam logic [3:0] BPIECE_ROOK   = 4'hC;
    localparam logic [3:0] BPIECE_QUEEN  = 4'hD;
    localparam logic [3:0] BPIECE_KING   = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EVAL,
        ST_DISPATCH,
        ST_WAIT,
        ST_DONE
    } sched_state_t;

    // A square belongs to the side to move when occupied and the colour bit matches.
    function automatic logic is_own(input logic [3:0] code, input logic side);
        return (code != PIECE_NONE) && (code[COLOUR_BIT] == side);
    endfunction

endpackage

// File: rtl/sat_accum.sv
// Saturating accumulator with synchronous clear; the sum clamps at all-ones
// instead of wrapping.
module sat_accum #(
    parameter int TOTAL_W = 8,
    parameter int CNT_W   = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               add_en,
    input  logic [CNT_W-1:0]   addend,
    output logic [TOTAL_W-1:0] total
);
    logic [TOTAL_W-1:0] total_q;
    logic [TOTAL_W-1:0] total_d;
    logic [TOTAL_W:0]   sum;

    always_comb begin
        sum     = {1'b0, total_q} + (TOTAL_W+1)'(addend);
        total_d = total_q;
        if (clear) begin
            total_d = '0;
        end else if (add_en) begin
            total_d = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign total = total_q;

endmodule

// File: rtl/move_gen_scheduler.sv
// Scans the 64 board squares for one side, hands each own piece to the move
// checker over valid/ready and accumulates the returned move counts.
module move_gen_scheduler
    import chess_pkg::*;
#(
    parameter int SQ_W    = 6,
    parameter int CNT_W   = 6,
    parameter int TOTAL_W = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               player,
    output logic               sq_rd_en,
    output logic [SQ_W-1:0]    sq_addr,
    input  logic [3:0]         sq_data,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [SQ_W-1:0]    req_square,
    output logic [3:0]         req_piece,
    input  logic               rsp_valid,
    input  logic [CNT_W-1:0]   rsp_count,
    output logic               busy,
    output logic               done,
    output logic [4:0]         pieces_found,
    output logic [TOTAL_W-1:0] total_moves,
    output logic               timeout_err
);
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    sched_state_t      state_q;
    logic [SQ_W-1:0]   sq_q;
    logic              player_q;
    logic              sq_rd_en_q;
    logic              req_valid_q;
    logic [SQ_W-1:0]   req_square_q;
    logic [3:0]        req_piece_q;
    logic              busy_q;
    logic              done_q;
    logic [4:0]        pieces_q;
    logic              timeout_q;
    logic [WAIT_W-1:0] wait_q;

    logic own_sq;
    logic wait_expired;
    logic last_sq;
    logic advance;
    logic acc_clear;
    logic acc_add;

    always_comb begin
        own_sq       = is_own(sq_data, player_q);
        wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1));
        last_sq      = (sq_q == {SQ_W{1'b1}});
        advance      = ((state_q == ST_EVAL) && !own_sq) ||
                       ((state_q == ST_WAIT) && (rsp_valid || wait_expired));
        acc_clear    = (state_q == ST_IDLE) && start && !abort;
        acc_add      = (state_q == ST_WAIT) && rsp_valid && !abort;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sq_q         <= '0;
            player_q     <= 1'b0;
            sq_rd_en_q   <= 1'b0;
            req_valid_q  <= 1'b0;
            req_square_q <= '0;
            req_piece_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pieces_q     <= '0;
            timeout_q    <= 1'b0;
            wait_q       <= '0;
        end else if (abort) begin
            // Counters and the latched request are deliberately left frozen.
            state_q     <= ST_IDLE;
            sq_rd_en_q  <= 1'b0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sq_rd_en_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        player_q   <= player;
                        pieces_q   <= '0;
                        timeout_q  <= 1'b0;
                        sq_q       <= '0;
                        sq_rd_en_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_READ;
                    end
                end
                ST_READ: state_q <= ST_EVAL;
                ST_EVAL: begin
                    if (own_sq) begin
                        req_square_q <= sq_q;
                        req_piece_q  <= sq_data;
                        req_valid_q  <= 1'b1;
                        state_q      <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    if (req_ready) begin
                        req_valid_q <= 1'b0;
                        pieces_q    <= pieces_q + 5'd1;
                        wait_q      <= '0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!rsp_valid && wait_expired) begin
                        timeout_q <= 1'b1;
                    end else if (!rsp_valid) begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            // Shared exit from EVAL (non-own square) and WAIT (response or timeout).
            if (advance) begin
                if (last_sq) begin
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end else begin
                    sq_q       <= sq_q + SQ_W'(1);
                    sq_rd_en_q <= 1'b1;
                    state_q    <= ST_READ;
                end
            end
        end
    end

    sat_accum #(
        .TOTAL_W (TOTAL_W),
        .CNT_W   (CNT_W)
    ) u_sat_accum (
        .clock  (clock),
        .reset  (reset),
        .clear  (acc_clear),
        .add_en (acc_add),
        .addend (rsp_count),
        .total  (total_moves)
    );

    assign sq_rd_en     = sq_rd_en_q;
    assign sq_addr      = sq_q;
    assign req_valid    = req_valid_q;
    assign req_square   = req_square_q;
    assign req_piece    = req_piece_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pieces_found = pieces_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_move_gen_scheduler.sv
// Bench for move_gen_scheduler: board memory model, checker stub and a
// square-list reference model derived from the ownership rule.
module tb_move_gen_scheduler;
    import chess_pkg::*;

    localparam int TOUT = 8;

    logic       clock = 1'b0;
    logic       reset, start, abort, player;
    logic       sq_rd_en, req_valid, req_ready, rsp_valid, busy, done, timeout_err;
    logic [5:0] sq_addr, req_square, rsp_count;
    logic [3:0] sq_data, req_piece;
    logic [4:0] pieces_found;
    logic [7:0] total_moves;

    always #5 clock = ~clock;

    move_gen_scheduler #(.SQ_W(6), .CNT_W(6), .TOTAL_W(8), .TIMEOUT(TOUT)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .player(player),
        .sq_rd_en(sq_rd_en), .sq_addr(sq_addr), .sq_data(sq_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_square(req_square),
        .req_piece(req_piece), .rsp_valid(rsp_valid), .rsp_count(rsp_count),
        .busy(busy), .done(done), .pieces_found(pieces_found),
        .total_moves(total_moves), .timeout_err(timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Board store: one-cycle read latency.
    logic [3:0] board [64];
    always @(posedge clock) if (sq_rd_en) sq_data <= board[sq_addr];

    // Checker stub configuration (written by the test process only).
    int cfg_silent_sq = -1;
    int cfg_cnt_mode  = 0;
    int cfg_cnt_fixed = 1;
    int cfg_stall_n   = 0;
    int stall_gen     = 0;
    int inject_req    = 0;

    // Stub state and logs (written by the stub only).
    int         stall_seen  = 0;
    int         stall_left  = 0;
    int         inject_done = 0;
    int         rsp_cd      = -1;
    logic [5:0] pend_cnt;
    int         req_log_sq[$];
    int         req_log_pc[$];
    int         rsp_log[$];
    int         stall_vld_log[$];
    int         stall_sq_log[$];
    int         n_done = 0;

    always @(negedge clock) if (done === 1'b1) n_done++;

    always @(negedge clock) begin
        rsp_valid = 1'b0;
        if (rsp_cd == 0) begin
            rsp_valid = 1'b1;
            rsp_count = pend_cnt;
            rsp_log.push_back(int'(pend_cnt));
            rsp_cd = -1;
        end else if (rsp_cd > 0) begin
            rsp_cd--;
        end
        if (inject_req != inject_done) begin
            inject_done = inject_req;
            rsp_valid   = 1'b1;
            rsp_count   = 6'd5;
        end
        req_ready = 1'b0;
        if (stall_gen != stall_seen && req_valid) begin
            stall_seen = stall_gen;
            stall_left = cfg_stall_n;
        end
        if (stall_left > 0) begin
            stall_vld_log.push_back(int'(req_valid));
            stall_sq_log.push_back(int'(req_square));
            stall_left--;
        end else if (req_valid) begin
            req_ready = 1'b1;
            req_log_sq.push_back(int'(req_square));
            req_log_pc.push_back(int'(req_piece));
            if (int'(req_square) != cfg_silent_sq) begin
                pend_cnt = (cfg_cnt_mode != 0) ? 6'($urandom_range(0, 63)) : 6'(cfg_cnt_fixed);
                rsp_cd   = 1;
            end
        end
    end

    task automatic set_empty();
        for (int s = 0; s < 64; s++) board[s] = PIECE_NONE;
    endtask

    task automatic set_initial();
        logic [3:0] back [8];
        back = '{PIECE_ROOK, PIECE_KNIGHT, PIECE_BISHOP, PIECE_QUEEN,
                 PIECE_KING, PIECE_BISHOP, PIECE_KNIGHT, PIECE_ROOK};
        set_empty();
        for (int f = 0; f < 8; f++) begin
            board[f]      = back[f];
            board[8 + f]  = PIECE_PAWN;
            board[48 + f] = BPIECE_PAWN;
            board[56 + f] = back[f] | 4'h8;
        end
    endtask

    task automatic set_random_board();
        int nw, nb;
        logic [3:0] pc;
        nw = 0;
        nb = 0;
        for (int s = 0; s < 64; s++) begin
            pc = PIECE_NONE;
            if ($urandom_range(0, 2) == 0) pc = 4'($urandom_range(1, 15));
            if (pc != 4'h0 && pc[3] && nb >= 16) pc = PIECE_NONE;
            if (pc != 4'h0 && !pc[3] && nw >= 16) pc = PIECE_NONE;
            if (pc != 4'h0) begin
                if (pc[3]) nb++;
                else nw++;
            end
            board[s] = pc;
        end
    endtask

    // Called at a negedge with the DUT idle; returns cycles from start edge to done.
    task automatic run_scan(input logic pl, input bit mid_start, output int cycles);
        player = pl;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        cycles = 1;
        check("busy_rise", int'(busy), 1);
        check("clr_pieces", int'(pieces_found), 0);
        check("clr_total", int'(total_moves), 0);
        check("clr_timeout", int'(timeout_err), 0);
        while (done !== 1'b1 && cycles < 20000) begin
            if (mid_start) start = (cycles == 40);
            @(negedge clock);
            cycles++;
        end
        start = 1'b0;
        check("done_seen", int'(done === 1'b1), 1);
        @(negedge clock);
        check("busy_fall", int'(busy), 0);
        check("done_pulse", int'(done), 0);
    endtask

    // Reference: requests are the own squares in ascending order; the total is
    // the clamped sum of delivered responses; a silent own square sets timeout.
    task automatic check_scan(input logic pl, input int base_req, input int base_rsp,
                              input int silent, input int done_before);
        int exp_sq[$];
        int sum;
        int exp_to;
        sum    = 0;
        exp_to = 0;
        for (int s = 0; s < 64; s++)
            if (board[s] != 4'h0 && board[s][3] == pl) exp_sq.push_back(s);
        foreach (exp_sq[i]) if (exp_sq[i] == silent) exp_to = 1;
        for (int i = base_rsp; i < rsp_log.size(); i++) sum += rsp_log[i];
        if (sum > 255) sum = 255;
        check("req_count", req_log_sq.size() - base_req, exp_sq.size());
        for (int i = 0; i < exp_sq.size() && base_req + i < req_log_sq.size(); i++) begin
            check("req_square", req_log_sq[base_req + i], exp_sq[i]);
            check("req_piece", req_log_pc[base_req + i], int'(board[exp_sq[i]]));
        end
        check("pieces_found", int'(pieces_found), exp_sq.size());
        check("total_moves", int'(total_moves), sum);
        check("timeout_err", int'(timeout_err), exp_to);
        check("done_count", n_done - done_before, 1);
    endtask

    int cyc, br, bs, dn, bst;
    logic rpl;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        player = 1'b0;
        set_empty();
        repeat (3) @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_req_valid", int'(req_valid), 0);
        check("rst_sq_rd_en", int'(sq_rd_en), 0);
        check("rst_sq_addr", int'(sq_addr), 0);
        check("rst_req_square", int'(req_square), 0);
        check("rst_req_piece", int'(req_piece), 0);
        check("rst_pieces", int'(pieces_found), 0);
        check("rst_total", int'(total_moves), 0);
        check("rst_timeout", int'(timeout_err), 0);
        reset = 1'b0;
        @(negedge clock);

        // White initial position, with a start pulse mid-scan that must be ignored.
        set_initial();
        br = req_log_sq.size(); bs = rsp_log.size(); dn = n_done;
        run_scan(1'b0, 1'b1, cyc);
        check_scan(1'b0, br, bs, -1, dn);
        check("t1_total16", int'(total_moves), 16);

        // Black side of the same board.
        br = req_log_sq.size(); bs = rsp_log.size(); dn = n_done;
        run_scan(1'b1, 1'b0, cyc);
        check_scan(1'b1, br, bs, -1, dn);
        for (int i = br; i < req_log_pc.size(); i++)
            check("t2_colour_bit", (req_log_pc[i] >> 3) & 1, 1);

        // Empty board: fixed 129-cycle latency, no requests.
        set_empty();
        br = req_log_sq.size(); bs = rsp_log.size(); dn = n_done;
        run_scan(1'b0, 1'b0, cyc);
        check("t3_cycles", cyc, 129);
        check_scan(1'b0, br, bs, -1, dn);

        // Ready held low for 5 cycles on the first request.
        set_initial();
        cfg_stall_n = 5;
        stall_gen++;
        bst = stall_vld_log.size();
        br = req_log_sq.size(); bs = rsp_log.size(); dn = n_done;
        run_scan(1'b0, 1'b0, cyc);
        check_scan(1'b0, br, bs, -1, dn);
        check("t4_stall_len", stall_vld_log.size() - bst, 5);
        for (int i = bst; i < stall_vld_log.size(); i++) begin
            check("t4_stall_valid", stall_vld_log[i], 1);
            check("t4_stall_square", stall_sq_log[i], 0);
        end
        cfg_stall_n = 0;

        // Square 4 never answered: timeout, scan continues.
        cfg_silent_sq = 4;
        br = req_log_sq.size(); bs = rsp_log.size(); dn = n_done;
        run_scan(1'b0, 1'b0, cyc);
        check_scan(1'b0, br, bs, 4, dn);
        check("t5_total15", int'(total_moves), 15);
        cfg_silent_sq = -1;

        // Saturation.
        cfg_cnt_fixed = 63;
        br = req_log_sq.size(); bs = rsp_log.size(); dn = n_done;
        run_scan(1'b0, 1'b0, cyc);
        check_scan(1'b0, br, bs, -1, dn);
        check("t6_saturated", int'(total_moves), 255);
        cfg_cnt_fixed = 1;

        // Random boards, sides and counts.
        cfg_cnt_mode = 1;
        for (int it = 0; it < 4; it++) begin
            set_random_board();
            rpl = 1'($urandom_range(0, 1));
            br = req_log_sq.size(); bs = rsp_log.size(); dn = n_done;
            run_scan(rpl, 1'b0, cyc);
            check_scan(rpl, br, bs, -1, dn);
        end
        cfg_cnt_mode = 0;

        // Abort while waiting for a response; a late response must be ignored.
        set_initial();
        cfg_silent_sq = 0;
        br = req_log_sq.size(); dn = n_done;
        player = 1'b0;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc   = 0;
        while (req_log_sq.size() == br && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        check("t6b_reached_wait", int'(req_log_sq.size() > br), 1);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("t6b_busy", int'(busy), 0);
        check("t6b_req_valid", int'(req_valid), 0);
        check("t6b_done", int'(done), 0);
        check("t6b_pieces", int'(pieces_found), 1);
        inject_req++;
        repeat (3) @(negedge clock);
        check("t6b_total_frozen", int'(total_moves), 0);
        check("t6b_pieces_frozen", int'(pieces_found), 1);
        check("t6b_still_idle", int'(busy), 0);
        check("t6b_no_done", n_done - dn, 0);
        cfg_silent_sq = -1;

        // Reset in the middle of a scan.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (30) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mrst_busy", int'(busy), 0);
        check("mrst_req_valid", int'(req_valid), 0);
        check("mrst_sq_rd_en", int'(sq_rd_en), 0);
        check("mrst_sq_addr", int'(sq_addr), 0);
        check("mrst_req_square", int'(req_square), 0);
        check("mrst_pieces", int'(pieces_found), 0);
        check("mrst_total", int'(total_moves), 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
